// File: rtl/cim_pkg.sv
// Shared helpers for the pipelined CIM macro array.
// - Derived-width functions (dot-product and psum widths).
// - Flat-bus index helpers for the packed activation and psum buses.
// - Signed saturation to an arbitrary psum width.
package cim_pkg;

    // Exact width of a ROWS-long sum of W_BITS x A_BITS signed products
    function automatic int dot_bits_fn(input int w_bits, input int a_bits, input int rows);
        return w_bits + a_bits + $clog2(rows);
    endfunction

    // Accumulator width: dot width plus guard bits
    function automatic int psum_bits_fn(input int dot_bits, input int acc_ext);
        return dot_bits + acc_ext;
    endfunction

    // Bit offset of channel c, row k in the packed activation bus
    function automatic int act_idx(input int c, input int k, input int rows, input int a_bits);
        return (c * rows + k) * a_bits;
    endfunction

    // Bit offset of channel c, column j in the packed psum bus
    function automatic int psum_idx(input int c, input int j, input int cols, input int p_bits);
        return (c * cols + j) * p_bits;
    endfunction

    // Clamp a signed value to the range of a p_bits-wide two's complement number
    function automatic logic signed [63:0] sat_fn(input logic signed [63:0] v, input int p_bits);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (p_bits - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (p_bits - 1));
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/cim_col_dot.sv
// One ROWS-long signed dot product, pipelined as two registered half-tree sums
// whose final add is combinational (it feeds the accumulator register).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en           load the half sums this cycle
//   act_signed   activations sign-extended (1) or zero-extended (0)
//   act_vec      ROWS activations, row k at [k*A_BITS +: A_BITS]
//   w_vec        ROWS signed weights, row k at [k*W_BITS +: W_BITS]
//   dot          exact signed dot product of the last loaded operands
module cim_col_dot #(
    parameter int ROWS     = 64,
    parameter int W_BITS   = 4,
    parameter int A_BITS   = 4,
    parameter int DOT_BITS = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       act_signed,
    input  logic [ROWS*A_BITS-1:0]     act_vec,
    input  logic [ROWS*W_BITS-1:0]     w_vec,
    output logic signed [DOT_BITS-1:0] dot
);
    localparam int HALF = ROWS / 2;

    logic signed [DOT_BITS-1:0] lo_s;
    logic signed [DOT_BITS-1:0] hi_s;
    logic signed [DOT_BITS-1:0] lo_r;
    logic signed [DOT_BITS-1:0] hi_r;

    // Single product; the activation gets one extra bit so unsigned values stay positive
    function automatic logic signed [DOT_BITS-1:0] prod_fn(input logic [A_BITS-1:0] a,
                                                           input logic [W_BITS-1:0] w,
                                                           input logic sgn);
        logic signed [A_BITS:0]   a_x;
        logic signed [W_BITS-1:0] w_x;
        a_x = signed'({sgn & a[A_BITS-1], a});
        w_x = signed'(w);
        return DOT_BITS'(a_x) * DOT_BITS'(w_x);
    endfunction

    // Two half-tree sums over the lower and upper row halves
    always_comb begin
        lo_s = '0;
        hi_s = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (k < HALF) begin
                lo_s = lo_s + prod_fn(act_vec[k*A_BITS +: A_BITS], w_vec[k*W_BITS +: W_BITS], act_signed);
            end else begin
                hi_s = hi_s + prod_fn(act_vec[k*A_BITS +: A_BITS], w_vec[k*W_BITS +: W_BITS], act_signed);
            end
        end
    end

    // Half-sum pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_r <= '0;
            hi_r <= '0;
        end else if (en) begin
            lo_r <= lo_s;
            hi_r <= hi_s;
        end else begin
            lo_r <= lo_r;
            hi_r <= hi_r;
        end
    end

    assign dot = lo_r + hi_r;

endmodule

// File: rtl/cim_macro_array_pipe.sv
// Pipelined CIM macro array: ROWS x COLS signed weight store with a
// read/write port, an N_ACT-deep activation window (load or slide), an
// N_ACT x COLS grid of dot products and a saturating psum accumulator.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   std_we/std_re/std_addr  weight row write/read strobes and address
//   std_wdata/std_rdata     weight row data (col j at [j*W_BITS +: W_BITS])
//   std_rvalid              one-cycle pulse with each read
//   cim_en/slide_en         issue strobe and window update mode
//   act_signed/acc_en       per-issue activation signedness and accumulate
//   act_in                  N_ACT x ROWS activations
//   psum_valid/psum         result pulse (issue + 2 edges) and held psum bus
module cim_macro_array_pipe
    import cim_pkg::*;
#(
    parameter int ROWS    = 64,
    parameter int COLS    = 4,
    parameter int W_BITS  = 4,
    parameter int A_BITS  = 4,
    parameter int N_ACT   = 3,
    parameter int ACC_EXT = 4,
    localparam int AW        = $clog2(ROWS),
    localparam int DOT_BITS  = dot_bits_fn(W_BITS, A_BITS, ROWS),
    localparam int PSUM_BITS = psum_bits_fn(DOT_BITS, ACC_EXT)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            std_we,
    input  logic                            std_re,
    input  logic [AW-1:0]                   std_addr,
    input  logic [COLS*W_BITS-1:0]          std_wdata,
    output logic [COLS*W_BITS-1:0]          std_rdata,
    output logic                            std_rvalid,
    input  logic                            cim_en,
    input  logic                            slide_en,
    input  logic                            act_signed,
    input  logic                            acc_en,
    input  logic [N_ACT*ROWS*A_BITS-1:0]    act_in,
    output logic                            psum_valid,
    output logic [N_ACT*COLS*PSUM_BITS-1:0] psum
);
    localparam int WROW = COLS * W_BITS;
    localparam int AROW = ROWS * A_BITS;

    logic [WROW-1:0]                   w_mem_r   [ROWS];
    logic [WROW-1:0]                   w_snap_r  [ROWS];
    logic [ROWS*W_BITS-1:0]            wcol_s    [COLS];
    logic [AROW-1:0]                   win_r     [N_ACT];
    logic [AROW-1:0]                   win_next_s[N_ACT];
    logic signed [DOT_BITS-1:0]        dot_s     [N_ACT*COLS];
    logic [WROW-1:0]                   std_rdata_r;
    logic                              std_rvalid_r;
    logic                              v1_r, sgn1_r, acc1_r;
    logic                              v2_r, acc2_r;
    logic [N_ACT*COLS*PSUM_BITS-1:0]   psum_r;
    logic [N_ACT*COLS*PSUM_BITS-1:0]   psum_next_s;
    logic                              psum_valid_r;

    // Psum update: overwrite, or add and clamp onto the current register
    function automatic logic [PSUM_BITS-1:0] acc_fn(input logic signed [PSUM_BITS-1:0] prev,
                                                    input logic signed [DOT_BITS-1:0]  d,
                                                    input logic                        acc);
        logic signed [63:0] sum;
        if (acc) begin
            sum = 64'(prev) + 64'(d);
            return PSUM_BITS'(sat_fn(sum, PSUM_BITS));
        end else begin
            return PSUM_BITS'(d);
        end
    endfunction

    // Weight store, read port (read-before-write) and per-issue weight snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                w_mem_r[r]  <= '0;
                w_snap_r[r] <= '0;
            end
            std_rdata_r  <= '0;
            std_rvalid_r <= 1'b0;
        end else begin
            if (std_we) begin
                w_mem_r[std_addr] <= std_wdata;
            end else begin
                w_mem_r[std_addr] <= w_mem_r[std_addr];
            end
            if (std_re) begin
                std_rdata_r <= w_mem_r[std_addr];
            end else begin
                std_rdata_r <= std_rdata_r;
            end
            std_rvalid_r <= std_re;
            // The snapshot takes pre-edge weights, hiding a same-edge write from this issue
            if (cim_en) begin
                w_snap_r <= w_mem_r;
            end else begin
                w_snap_r <= w_snap_r;
            end
        end
    end

    // Regroup the weight snapshot into one column vector per output column
    always_comb begin
        for (int j = 0; j < COLS; j++) begin
            wcol_s[j] = '0;
        end
        for (int j = 0; j < COLS; j++) begin
            for (int k = 0; k < ROWS; k++) begin
                wcol_s[j][k*W_BITS +: W_BITS] = w_snap_r[k][j*W_BITS +: W_BITS];
            end
        end
    end

    // Next window: load every channel, or shift down and append act_in channel 0
    always_comb begin
        for (int c = 0; c < N_ACT; c++) begin
            win_next_s[c] = win_r[c];
        end
        for (int c = 0; c < N_ACT - 1; c++) begin
            win_next_s[c] = slide_en ? win_r[c+1] : act_in[act_idx(c, 0, ROWS, A_BITS) +: AROW];
        end
        win_next_s[N_ACT-1] = slide_en ? act_in[act_idx(0, 0, ROWS, A_BITS) +: AROW]
                                       : act_in[act_idx(N_ACT-1, 0, ROWS, A_BITS) +: AROW];
    end

    // Window register and issue sideband pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_ACT; c++) begin
                win_r[c] <= '0;
            end
            v1_r   <= 1'b0;
            sgn1_r <= 1'b0;
            acc1_r <= 1'b0;
            v2_r   <= 1'b0;
            acc2_r <= 1'b0;
        end else begin
            if (cim_en) begin
                win_r <= win_next_s;
            end else begin
                win_r <= win_r;
            end
            v1_r   <= cim_en;
            sgn1_r <= act_signed;
            acc1_r <= acc_en;
            v2_r   <= v1_r;
            acc2_r <= acc1_r;
        end
    end

    for (genvar c = 0; c < N_ACT; c++) begin : g_ch
        for (genvar j = 0; j < COLS; j++) begin : g_col
            cim_col_dot #(
                .ROWS    (ROWS),
                .W_BITS  (W_BITS),
                .A_BITS  (A_BITS),
                .DOT_BITS(DOT_BITS)
            ) u_dot (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (v1_r),
                .act_signed(sgn1_r),
                .act_vec   (win_r[c]),
                .w_vec     (wcol_s[j]),
                .dot       (dot_s[c*COLS+j])
            );
        end
    end

    // Accumulator next value for every channel/column
    always_comb begin
        psum_next_s = psum_r;
        for (int c = 0; c < N_ACT; c++) begin
            for (int j = 0; j < COLS; j++) begin
                if (v2_r) begin
                    psum_next_s[psum_idx(c, j, COLS, PSUM_BITS) +: PSUM_BITS] =
                        acc_fn(psum_r[psum_idx(c, j, COLS, PSUM_BITS) +: PSUM_BITS], dot_s[c*COLS+j], acc2_r);
                end else begin
                    psum_next_s[psum_idx(c, j, COLS, PSUM_BITS) +: PSUM_BITS] =
                        psum_r[psum_idx(c, j, COLS, PSUM_BITS) +: PSUM_BITS];
                end
            end
        end
    end

    // Psum register and valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_r       <= '0;
            psum_valid_r <= 1'b0;
        end else begin
            psum_r       <= psum_next_s;
            psum_valid_r <= v2_r;
        end
    end

    assign std_rdata  = std_rdata_r;
    assign std_rvalid = std_rvalid_r;
    assign psum       = psum_r;
    assign psum_valid = psum_valid_r;

endmodule

// File: tb/tb_cim_macro_array_pipe.sv
// Directed bench for cim_macro_array_pipe at default parameters.
module tb_cim_macro_array_pipe;
    localparam int ROWS = 64, COLS = 4, W_BITS = 4, A_BITS = 4, N_ACT = 3;
    localparam int AW = 6, PB = 18;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          std_we = 1'b0, std_re = 1'b0;
    logic [AW-1:0]                 std_addr = '0;
    logic [COLS*W_BITS-1:0]        std_wdata = '0;
    logic [COLS*W_BITS-1:0]        std_rdata;
    logic                          std_rvalid;
    logic                          cim_en = 1'b0, slide_en = 1'b0, act_signed = 1'b0, acc_en = 1'b0;
    logic [N_ACT*ROWS*A_BITS-1:0]  act_in = '0;
    logic                          psum_valid;
    logic [N_ACT*COLS*PB-1:0]      psum;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [15:0] wrow;
        logic [3:0]  a [3];
        logic        sgn;
        int          exp [3][4];
    } vec_t;
    vec_t vecs [4];

    cim_macro_array_pipe dut (
        .clk(clk), .rst_n(rst_n), .std_we(std_we), .std_re(std_re), .std_addr(std_addr),
        .std_wdata(std_wdata), .std_rdata(std_rdata), .std_rvalid(std_rvalid),
        .cim_en(cim_en), .slide_en(slide_en), .act_signed(act_signed), .acc_en(acc_en),
        .act_in(act_in), .psum_valid(psum_valid), .psum(psum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int get_psum(input int c, input int j);
        logic signed [PB-1:0] v;
        v = psum[(c*COLS+j)*PB +: PB];
        return int'(v);
    endfunction

    task automatic set_acts(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        for (int k = 0; k < ROWS; k++) begin
            act_in[(0*ROWS+k)*A_BITS +: A_BITS] = a0;
            act_in[(1*ROWS+k)*A_BITS +: A_BITS] = a1;
            act_in[(2*ROWS+k)*A_BITS +: A_BITS] = a2;
        end
    endtask

    task automatic write_all(input logic [15:0] wrow);
        for (int r = 0; r < ROWS; r++) begin
            std_we = 1'b1;
            std_addr = AW'(r);
            std_wdata = wrow;
            tick();
        end
        std_we = 1'b0;
    endtask

    task automatic chk_all(input string nm, input int exp);
        for (int c = 0; c < N_ACT; c++) begin
            for (int j = 0; j < COLS; j++) begin
                chk($sformatf("%s ch%0d col%0d", nm, c, j), get_psum(c, j), exp);
            end
        end
    endtask

    initial begin
        vecs[0].name = "load_unsigned"; vecs[0].wrow = 16'h1111; vecs[0].a = '{4'd3, 4'd0, 4'd15}; vecs[0].sgn = 1'b0;
        vecs[0].exp = '{'{192, 192, 192, 192}, '{0, 0, 0, 0}, '{960, 960, 960, 960}};
        vecs[1].name = "neg_w_signed"; vecs[1].wrow = 16'h8888; vecs[1].a = '{4'hF, 4'hF, 4'hF}; vecs[1].sgn = 1'b1;
        vecs[1].exp = '{'{512, 512, 512, 512}, '{512, 512, 512, 512}, '{512, 512, 512, 512}};
        vecs[2].name = "neg_w_unsigned"; vecs[2].wrow = 16'h8888; vecs[2].a = '{4'hF, 4'hF, 4'hF}; vecs[2].sgn = 1'b0;
        vecs[2].exp = '{'{-7680, -7680, -7680, -7680}, '{-7680, -7680, -7680, -7680}, '{-7680, -7680, -7680, -7680}};
        vecs[3].name = "mixed_cols"; vecs[3].wrow = 16'h7F18; vecs[3].a = '{4'd2, 4'd9, 4'd0}; vecs[3].sgn = 1'b1;
        vecs[3].exp = '{'{-1024, 128, -128, 896}, '{3584, -448, 448, -3136}, '{0, 0, 0, 0}};

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst psum_valid", int'(psum_valid), 0);
        chk("rst std_rvalid", int'(std_rvalid), 0);
        chk("rst std_rdata", int'(std_rdata), 0);
        chk_all("rst psum", 0);
        rst_n = 1'b1;
        tick();

        // STD write then read, then same-cycle write/read
        std_we = 1'b1; std_addr = 6'd5; std_wdata = 16'h0007; tick();
        std_we = 1'b0; std_re = 1'b1; tick();
        chk("std read data", int'(std_rdata), 32'h0007);
        chk("std rvalid", int'(std_rvalid), 1);
        std_re = 1'b0; tick();
        chk("std rvalid pulse", int'(std_rvalid), 0);
        chk("std rdata hold", int'(std_rdata), 32'h0007);
        std_we = 1'b1; std_re = 1'b1; std_wdata = 16'h0009; tick();
        std_we = 1'b0; std_re = 1'b0;
        chk("std rbw old data", int'(std_rdata), 32'h0007);
        std_re = 1'b1; tick();
        std_re = 1'b0;
        chk("std new data", int'(std_rdata), 32'h0009);

        // Table-driven load-mode issues
        for (int v = 0; v < 4; v++) begin
            write_all(vecs[v].wrow);
            set_acts(vecs[v].a[0], vecs[v].a[1], vecs[v].a[2]);
            act_signed = vecs[v].sgn; slide_en = 1'b0; acc_en = 1'b0; cim_en = 1'b1;
            tick();
            cim_en = 1'b0;
            tick();
            chk({vecs[v].name, " valid n+1"}, int'(psum_valid), 0);
            tick();
            chk({vecs[v].name, " valid n+2"}, int'(psum_valid), 1);
            for (int c = 0; c < N_ACT; c++) begin
                for (int j = 0; j < COLS; j++) begin
                    chk($sformatf("%s ch%0d col%0d", vecs[v].name, c, j), get_psum(c, j), vecs[v].exp[c][j]);
                end
            end
            tick();
            chk({vecs[v].name, " valid pulse"}, int'(psum_valid), 0);
        end

        // Reset in the middle of an issue
        std_re = 1'b1; std_addr = 6'd5; tick();
        std_re = 1'b0;
        set_acts(4'd1, 4'd1, 4'd1); act_signed = 1'b0; cim_en = 1'b1;
        tick();
        cim_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst psum_valid", int'(psum_valid), 0);
        chk("midrst std_rvalid", int'(std_rvalid), 0);
        chk("midrst std_rdata", int'(std_rdata), 0);
        chk_all("midrst psum", 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no stray valid", int'(psum_valid), 0);
        end
        std_re = 1'b1; std_addr = 6'd5; tick();
        std_re = 1'b0;
        chk("weights cleared", int'(std_rdata), 0);

        // Slide mode, three back-to-back issues; other channels carry junk
        write_all(16'h1111);
        act_signed = 1'b0; slide_en = 1'b1; acc_en = 1'b0; cim_en = 1'b1;
        set_acts(4'd1, 4'd15, 4'd15); tick();
        set_acts(4'd2, 4'd15, 4'd15); tick();
        set_acts(4'd3, 4'd15, 4'd15); tick();
        cim_en = 1'b0; slide_en = 1'b0;
        chk("slide1 valid", int'(psum_valid), 1);
        chk("slide1 ch0", get_psum(0, 0), 0);
        chk("slide1 ch1", get_psum(1, 1), 0);
        chk("slide1 ch2", get_psum(2, 3), 64);
        tick();
        chk("slide2 valid", int'(psum_valid), 1);
        chk("slide2 ch0", get_psum(0, 2), 0);
        chk("slide2 ch1", get_psum(1, 0), 64);
        chk("slide2 ch2", get_psum(2, 1), 128);
        tick();
        chk("slide3 valid", int'(psum_valid), 1);
        chk("slide3 ch0", get_psum(0, 3), 64);
        chk("slide3 ch1", get_psum(1, 2), 128);
        chk("slide3 ch2", get_psum(2, 0), 192);
        tick();
        chk("slide end valid", int'(psum_valid), 0);

        // Saturating accumulation chain with a same-cycle weight write
        write_all(16'h7777);
        set_acts(4'd15, 4'd15, 4'd15); act_signed = 1'b0; slide_en = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cim_en = 1'b1;
            acc_en = (i > 1) ? 1'b1 : 1'b0;
            std_we = (i == 19) ? 1'b1 : 1'b0;
            std_addr = 6'd0; std_wdata = 16'h0000;
            tick();
            if (i >= 3) begin
                chk($sformatf("acc valid %0d", i - 2), int'(psum_valid), 1);
                chk($sformatf("acc issue %0d", i - 2), get_psum(2, 3), (i - 2) * 6720);
            end
        end
        cim_en = 1'b0; acc_en = 1'b0; std_we = 1'b0;
        tick();
        chk_all("acc issue 19", 127680);
        tick();
        chk_all("acc issue 20 sat", 131071);
        tick();
        chk("acc hold valid", int'(psum_valid), 0);
        chk("acc hold psum", get_psum(1, 2), 131071);
        cim_en = 1'b1; tick();
        cim_en = 1'b0; tick(); tick();
        chk_all("new weights", 6615);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
